// File: rtl/regfile_sb.sv
// Register file with ALU and memory write-back ports, two combinational read ports
// and a pending-load scoreboard. Define REGFILE_SB_BYPASS_EN for write-through forwarding.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              dst_busy
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // wr1 is applied after wr0 so the memory port wins a collision; issue after clear so set wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_en && !is_zero(wr0_addr)) regs_d[wr0_addr] = wr0_data;
        if (wr1_en && !is_zero(wr1_addr)) regs_d[wr1_addr] = wr1_data;
        if (wr1_en) busy_d[wr1_addr] = 1'b0;
        if (issue_en && !is_zero(issue_dst)) busy_d[issue_dst] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr1_en && wr1_addr == rd_addr_a)      rd_data_a = wr1_data;
        else if (wr0_en && wr0_addr == rd_addr_a) rd_data_a = wr0_data;
`endif
        if (reset || is_zero(rd_addr_a)) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr1_en && wr1_addr == rd_addr_b)      rd_data_b = wr1_data;
        else if (wr0_en && wr0_addr == rd_addr_b) rd_data_b = wr0_data;
`endif
        if (reset || is_zero(rd_addr_b)) rd_data_b = '0;
    end

    // Outputs are forced low while reset is held so nothing leaks before the first reset edge.
    always_comb begin
        busy_a   = !reset && busy_q[rd_addr_a];
        busy_b   = !reset && busy_q[rd_addr_b];
        dst_busy = !reset && busy_q[issue_dst];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, full-index sweep, then randomised traffic vs a model.
module tb_regfile_sb;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, issue_dst;
    logic [31:0] rd_data_a, rd_data_b, wr0_data, wr1_data;
    logic        busy_a, busy_b, wr0_en, wr1_en, issue_en, dst_busy;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_dst(issue_dst), .dst_busy(dst_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        ie;  logic [4:0] id;
        logic [4:0]  ra;  logic [4:0] rb;
        logic [31:0] ea;  logic [31:0] eb;
        logic        eba; logic ebb; logic edb;
    } vec_t;

    typedef struct {
        logic [31:0] a; logic [31:0] b;
        logic ba; logic bb; logic db;
    } exp_t;

    vec_t vecs[21];
    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    function automatic vec_t mk(input logic rst,
                                input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input logic ie, input logic [4:0] id,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic eba, input logic ebb, input logic edb);
        vec_t v;
        v.rst = rst; v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d; v.ie = ie; v.id = id;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.edb = edb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        reset = v.rst;
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        issue_en = v.ie; issue_dst = v.id;
        rd_addr_a = v.ra; rd_addr_b = v.rb;
        e.a = v.ea; e.b = v.eb; e.ba = v.eba; e.bb = v.ebb; e.db = v.edb;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        if (rd_data_a !== e.a) begin n_fail++; $display("FAIL %s rd_data_a: got %h want %h", name, rd_data_a, e.a); end
        if (rd_data_b !== e.b) begin n_fail++; $display("FAIL %s rd_data_b: got %h want %h", name, rd_data_b, e.b); end
        if (busy_a !== e.ba)   begin n_fail++; $display("FAIL %s busy_a: got %b want %b", name, busy_a, e.ba); end
        if (busy_b !== e.bb)   begin n_fail++; $display("FAIL %s busy_b: got %b want %b", name, busy_b, e.bb); end
        if (dst_busy !== e.db) begin n_fail++; $display("FAIL %s dst_busy: got %b want %b", name, dst_busy, e.db); end
    endtask

    // One cycle: inputs applied just after a rising edge, outputs checked on the falling edge.
    task automatic run_vec(input vec_t v, input string name);
        drive(v);
        @(negedge clock);
        check_out(name);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic rst, input logic [4:0] a,
                                           input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                           input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d);
        logic [31:0] r;
        r = m_regs[a];
        if (BYP) begin
            if (w1e && w1a == a) r = w1d;
            else if (w0e && w0a == a) r = w0d;
        end
        if (rst || a == 5'd0) r = 32'h0;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(1, 1,3,32'hDEAD, 0,0,0, 1,3, 3,0, 0,0, 0,0,0);
        vecs[1]  = mk(0, 0,0,0, 0,0,0, 0,3, 3,3, 0,0, 0,0,0);
        vecs[2]  = mk(0, 1,5,32'h12345678, 0,0,0, 0,0, 5,0, BYP ? 32'h12345678 : 32'h0, 0, 0,0,0);
        vecs[3]  = mk(0, 0,0,0, 0,0,0, 0,0, 5,5, 32'h12345678, 32'h12345678, 0,0,0);
        vecs[4]  = mk(0, 1,9,32'hAAAA0000, 1,9,32'h0000BBBB, 0,0, 9,5,
                      BYP ? 32'h0000BBBB : 32'h0, 32'h12345678, 0,0,0);
        vecs[5]  = mk(0, 0,0,0, 0,0,0, 0,0, 9,9, 32'h0000BBBB, 32'h0000BBBB, 0,0,0);
        vecs[6]  = mk(0, 0,0,0, 0,0,0, 1,7, 7,0, 0,0, 0,0,0);
        vecs[7]  = mk(0, 0,0,0, 0,0,0, 0,7, 7,7, 0,0, 1,1,1);
        vecs[8]  = mk(0, 0,0,0, 1,7,32'hCAFEF00D, 0,7, 7,0, BYP ? 32'hCAFEF00D : 32'h0, 0, 1,0,1);
        vecs[9]  = mk(0, 0,0,0, 0,0,0, 0,7, 7,0, 32'hCAFEF00D, 0, 0,0,0);
        vecs[10] = mk(0, 0,0,0, 1,7,32'h11112222, 1,7, 7,0, BYP ? 32'h11112222 : 32'hCAFEF00D, 0, 0,0,0);
        vecs[11] = mk(0, 0,0,0, 0,0,0, 0,7, 7,0, 32'h11112222, 0, 1,0,1);
        vecs[12] = mk(0, 1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0, 0,0, 0,0,0);
        vecs[13] = mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0,0);
        vecs[14] = mk(0, 1,3,32'h00000011, 0,0,0, 0,0, 3,3, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, 0,0,0);
        vecs[15] = mk(0, 0,0,0, 0,0,0, 0,0, 3,0, 32'h11, 0, 0,0,0);
        vecs[16] = mk(0, 1,3,32'h22, 1,4,32'h44, 0,7, 3,4,
                      BYP ? 32'h22 : 32'h11, BYP ? 32'h44 : 32'h0, 0,0,1);
        vecs[17] = mk(0, 1,7,32'h77, 0,0,0, 0,7, 7,3, BYP ? 32'h77 : 32'h11112222, 32'h22, 1,0,1);
        vecs[18] = mk(0, 0,0,0, 0,0,0, 0,7, 7,4, 32'h77, 32'h44, 1,0,1);
        vecs[19] = mk(1, 1,3,32'h99, 0,0,0, 0,7, 7,3, 0,0, 0,0,0);
        vecs[20] = mk(0, 0,0,0, 0,0,0, 0,7, 7,3, 0,0, 0,0,0);

        reset = 1'b1;
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        issue_en = 0; issue_dst = 0; rd_addr_a = 0; rd_addr_b = 0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 21; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 32; i++)
            run_vec(mk(0, 0,0,0, 0,0,0, 0,5'(i), 5'(i),5'(31-i), 0,0, 0,0,0), $sformatf("sweep%0d", i));

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
        for (int c = 0; c < 300; c++) begin
            vec_t v;
            v.rst = ($urandom_range(0, 29) == 0);
            v.w0e = $urandom_range(0, 1); v.w0a = 5'($urandom_range(0, 7)); v.w0d = $urandom;
            v.w1e = $urandom_range(0, 1); v.w1a = 5'($urandom_range(0, 7)); v.w1d = $urandom;
            v.ie  = $urandom_range(0, 1); v.id  = 5'($urandom_range(0, 7));
            v.ra  = 5'($urandom_range(0, 7)); v.rb = 5'($urandom_range(0, 7));
            v.ea  = m_read(v.rst, v.ra, v.w0e, v.w0a, v.w0d, v.w1e, v.w1a, v.w1d);
            v.eb  = m_read(v.rst, v.rb, v.w0e, v.w0a, v.w0d, v.w1e, v.w1a, v.w1d);
            v.eba = !v.rst && m_busy[v.ra];
            v.ebb = !v.rst && m_busy[v.rb];
            v.edb = !v.rst && m_busy[v.id];
            run_vec(v, $sformatf("rand%0d", c));
            if (v.rst) begin
                for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
                m_busy = 32'h0;
            end else begin
                if (v.w0e && v.w0a != 0) m_regs[v.w0a] = v.w0d;
                if (v.w1e && v.w1a != 0) m_regs[v.w1a] = v.w1d;
                if (v.w1e) m_busy[v.w1a] = 1'b0;
                if (v.ie && v.id != 0) m_busy[v.id] = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
